// File: rtl/tmr_rollback_ctrl.sv
// ============================================================================
//  Module      : tmr_rollback_ctrl
//  Description : Checkpoint/rollback controller for a TMR RISC-V core. It
//                stalls, drains and reloads all cores on a single-core fault,
//                and latches a fatal condition when no majority exists.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmr_rollback_ctrl #(
    parameter int STALL_CYCLES  = 4,
    parameter int RESUME_CYCLES = 5,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [31:0]      PC_Top_A,
    input  logic [31:0]      PC_Top_B,
    input  logic [31:0]      PC_Top_C,
    input  logic [31:0]      ALUResult_A,
    input  logic [31:0]      ALUResult_B,
    input  logic [31:0]      ALUResult_C,
    input  logic [31:0]      RD2_Top_A,
    input  logic [31:0]      RD2_Top_B,
    input  logic [31:0]      RD2_Top_C,
    input  logic             MemWrite_A,
    input  logic             MemWrite_B,
    input  logic             MemWrite_C,
    output logic             Stall,
    output logic             Mem_block,
    output logic             Reload,
    output logic [31:0]      Reload_PC,
    output logic [2:0]       Fault_mask,
    output logic [CNT_W-1:0] Fault_cnt_A,
    output logic [CNT_W-1:0] Fault_cnt_B,
    output logic [CNT_W-1:0] Fault_cnt_C,
    output logic             Fatal,
    output logic [2:0]       Ctrl_state
);

    typedef enum logic [2:0] {
        ST_MONITOR = 3'd0,
        ST_STALL   = 3'd1,
        ST_RELOAD  = 3'd2,
        ST_RESUME  = 3'd3,
        ST_FATAL   = 3'd4
    } state_t;

    localparam logic [3:0]       C_STALL_LAST  = 4'(STALL_CYCLES - 1);
    localparam logic [3:0]       C_RESUME_LAST = 4'(RESUME_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX     = '1;

    state_t           state_q, state_d;
    logic [3:0]       cyc_q, cyc_d;
    logic [31:0]      checkpoint_q, checkpoint_d;
    logic [2:0]       fault_mask_q, fault_mask_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0] cnt_c_q, cnt_c_d;
    logic             stall_q, stall_d;
    logic             reload_q, reload_d;
    logic             fatal_q, fatal_d;

    logic [96:0] w_word_a, w_word_b, w_word_c;
    logic        w_eq_ab, w_eq_bc, w_eq_ac;

    assign w_word_a = {PC_Top_A, ALUResult_A, RD2_Top_A, MemWrite_A};
    assign w_word_b = {PC_Top_B, ALUResult_B, RD2_Top_B, MemWrite_B};
    assign w_word_c = {PC_Top_C, ALUResult_C, RD2_Top_C, MemWrite_C};
    assign w_eq_ab  = (w_word_a == w_word_b);
    assign w_eq_bc  = (w_word_b == w_word_c);
    assign w_eq_ac  = (w_word_a == w_word_c);

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        checkpoint_d = checkpoint_q;
        fault_mask_d = fault_mask_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        cnt_c_d      = cnt_c_q;
        case (state_q)
            ST_MONITOR: begin
                // Two true flags imply the third, so only these cases exist
                if (w_eq_ab && w_eq_bc) begin
                    checkpoint_d = PC_Top_A;
                end else if (w_eq_bc) begin
                    fault_mask_d = 3'b100;
                    cnt_a_d      = (cnt_a_q == C_CNT_MAX) ? cnt_a_q : cnt_a_q + CNT_W'(1);
                    state_d      = ST_STALL;
                    cyc_d        = 4'd0;
                end else if (w_eq_ac) begin
                    fault_mask_d = 3'b010;
                    cnt_b_d      = (cnt_b_q == C_CNT_MAX) ? cnt_b_q : cnt_b_q + CNT_W'(1);
                    state_d      = ST_STALL;
                    cyc_d        = 4'd0;
                end else if (w_eq_ab) begin
                    fault_mask_d = 3'b001;
                    cnt_c_d      = (cnt_c_q == C_CNT_MAX) ? cnt_c_q : cnt_c_q + CNT_W'(1);
                    state_d      = ST_STALL;
                    cyc_d        = 4'd0;
                end else begin
                    state_d = ST_FATAL;
                end
            end
            ST_STALL: begin
                if (cyc_q == C_STALL_LAST) begin
                    state_d = ST_RELOAD;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            ST_RELOAD: begin
                state_d = ST_RESUME;
                cyc_d   = 4'd0;
            end
            ST_RESUME: begin
                if (cyc_q == C_RESUME_LAST) begin
                    state_d = ST_MONITOR;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            ST_FATAL: state_d = ST_FATAL;
            default:  state_d = ST_MONITOR;
        endcase
        // Registered outputs are decoded from the next state so they align with it
        stall_d  = (state_d == ST_STALL) || (state_d == ST_RELOAD) || (state_d == ST_FATAL);
        reload_d = (state_d == ST_RELOAD);
        fatal_d  = (state_d == ST_FATAL);
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= ST_MONITOR;
            cyc_q        <= 4'd0;
            checkpoint_q <= 32'd0;
            fault_mask_q <= 3'b000;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            cnt_c_q      <= '0;
            stall_q      <= 1'b0;
            reload_q     <= 1'b0;
            fatal_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            checkpoint_q <= checkpoint_d;
            fault_mask_q <= fault_mask_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            cnt_c_q      <= cnt_c_d;
            stall_q      <= stall_d;
            reload_q     <= reload_d;
            fatal_q      <= fatal_d;
        end
    end

    assign Stall       = stall_q;
    assign Mem_block   = stall_q | ((state_q == ST_MONITOR) & ~(w_eq_ab & w_eq_bc));
    assign Reload      = reload_q;
    assign Reload_PC   = checkpoint_q;
    assign Fault_mask  = fault_mask_q;
    assign Fault_cnt_A = cnt_a_q;
    assign Fault_cnt_B = cnt_b_q;
    assign Fault_cnt_C = cnt_c_q;
    assign Fatal       = fatal_q;
    assign Ctrl_state  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_tmr_rollback_ctrl.sv
// ============================================================================
//  Module      : tb_tmr_rollback_ctrl
//  Description : Self-checking bench for tmr_rollback_ctrl (vector table,
//                scoreboard queue and directed recovery sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tmr_rollback_ctrl;

    localparam int S = 4;
    localparam int R = 5;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [31:0] pc_a, pc_b, pc_c, alu_a, alu_b, alu_c, rd_a, rd_b, rd_c;
    logic        mw_a, mw_b, mw_c;
    logic        Stall, Mem_block, Reload, Fatal;
    logic [31:0] Reload_PC;
    logic [2:0]  Fault_mask, Ctrl_state;
    logic [3:0]  Fault_cnt_A, Fault_cnt_B, Fault_cnt_C;

    always #5 clk = ~clk;

    tmr_rollback_ctrl #(.STALL_CYCLES(S), .RESUME_CYCLES(R), .CNT_W(4)) dut (
        .clk(clk), .rst_in(rst_in),
        .PC_Top_A(pc_a), .PC_Top_B(pc_b), .PC_Top_C(pc_c),
        .ALUResult_A(alu_a), .ALUResult_B(alu_b), .ALUResult_C(alu_c),
        .RD2_Top_A(rd_a), .RD2_Top_B(rd_b), .RD2_Top_C(rd_c),
        .MemWrite_A(mw_a), .MemWrite_B(mw_b), .MemWrite_C(mw_c),
        .Stall(Stall), .Mem_block(Mem_block), .Reload(Reload), .Reload_PC(Reload_PC),
        .Fault_mask(Fault_mask), .Fault_cnt_A(Fault_cnt_A), .Fault_cnt_B(Fault_cnt_B),
        .Fault_cnt_C(Fault_cnt_C), .Fatal(Fatal), .Ctrl_state(Ctrl_state)
    );

    typedef struct packed {
        logic [31:0] pca, pcb, pcc, alua, alub, aluc, rda, rdb, rdc;
        logic [2:0]  mw;
        logic        mb;
        logic [2:0]  st;
        logic [2:0]  mask;
    } vec_t;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] mask;
        logic [3:0] ca, cb, cc;
    } exp_t;

    vec_t        vecs[11];
    exp_t        sbq[$];
    exp_t        e;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_cp;
    logic [3:0]  m_ca, m_cb, m_cc;
    logic [2:0]  m_mask;

    function automatic vec_t mk(input logic [31:0] pca, pcb, pcc, alua, alub, aluc,
                                input logic [31:0] rda, rdb, rdc, input logic [2:0] mw,
                                input logic mb, input logic [2:0] st, input logic [2:0] mask);
        vec_t v;
        v = '{pca, pcb, pcc, alua, alub, aluc, rda, rdb, rdc, mw, mb, st, mask};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [31:0] pc, input logic [31:0] alu);
        pc_a = pc;  pc_b = pc;  pc_c = pc;
        alu_a = alu; alu_b = alu; alu_c = alu;
        rd_a = 32'h100; rd_b = 32'h100; rd_c = 32'h100;
        mw_a = 1'b1; mw_b = 1'b1; mw_c = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        pc_a = v.pca;  pc_b = v.pcb;  pc_c = v.pcc;
        alu_a = v.alua; alu_b = v.alub; alu_c = v.aluc;
        rd_a = v.rda;  rd_b = v.rdb;  rd_c = v.rdc;
        {mw_a, mw_b, mw_c} = v.mw;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget);
        int k;
        k = 0;
        while (Ctrl_state !== target && k < budget) begin
            tick;
            k++;
        end
        if (Ctrl_state !== target) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_state: state 0x%0h, expected 0x%0h within %0d cycles", Ctrl_state, target, budget);
        end
    endtask

    // Entered just after the detection edge N
    task automatic check_recovery(input logic [31:0] cp);
        for (int k = 0; k < S; k++) begin
            chk("stall_phase_stall", 32'(Stall), 32'd1);
            chk("stall_phase_state", 32'(Ctrl_state), 32'd1);
            chk("stall_phase_reload", 32'(Reload), 32'd0);
            tick;
        end
        chk("reload_pulse", 32'(Reload), 32'd1);
        chk("reload_pc", Reload_PC, cp);
        chk("reload_stall", 32'(Stall), 32'd1);
        chk("reload_state", 32'(Ctrl_state), 32'd2);
        tick;
        for (int k = 0; k < R; k++) begin
            chk("resume_stall", 32'(Stall), 32'd0);
            chk("resume_state", 32'(Ctrl_state), 32'd3);
            chk("resume_reload", 32'(Reload), 32'd0);
            tick;
        end
        chk("back_to_monitor", 32'(Ctrl_state), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(32'h10, 32'h10, 32'h10, 5, 5, 5, 32'h100, 32'h100, 32'h100, 3'b111, 1'b0, 3'd0, 3'b000);
        vecs[1]  = vecs[0];
        vecs[2]  = vecs[0];
        vecs[3]  = mk(32'h10, 32'h10, 32'h10, 5, 5, 32'h77, 32'h100, 32'h100, 32'h100, 3'b111, 1'b1, 3'd1, 3'b001);
        vecs[4]  = mk(32'h20, 32'h20, 32'h20, 5, 5, 5, 32'h100, 32'h100, 32'h100, 3'b111, 1'b0, 3'd0, 3'b001);
        vecs[5]  = mk(32'h20, 32'h20, 32'h20, 5, 32'hDEADBEEF, 5, 32'h100, 32'h100, 32'h100, 3'b111, 1'b1, 3'd1, 3'b010);
        vecs[6]  = mk(32'h30, 32'h30, 32'h30, 5, 5, 5, 32'h100, 32'h100, 32'h100, 3'b111, 1'b0, 3'd0, 3'b010);
        vecs[7]  = mk(32'h34, 32'h30, 32'h30, 5, 5, 5, 32'h100, 32'h100, 32'h100, 3'b111, 1'b1, 3'd1, 3'b100);
        vecs[8]  = mk(32'h30, 32'h30, 32'h30, 5, 5, 5, 32'h100, 32'h100, 32'h100, 3'b110, 1'b1, 3'd1, 3'b001);
        vecs[9]  = mk(32'h30, 32'h30, 32'h30, 5, 5, 5, 32'h200, 32'h100, 32'h100, 3'b111, 1'b1, 3'd1, 3'b100);
        vecs[10] = mk(32'h4, 32'h8, 32'hC, 5, 5, 5, 32'h100, 32'h100, 32'h100, 3'b111, 1'b1, 3'd4, 3'b100);

        // Reset state
        rst_in = 1'b0;
        set_all(32'h10, 32'd5);
        #3;
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_reload", 32'(Reload), 32'd0);
        chk("rst_reload_pc", Reload_PC, 32'd0);
        chk("rst_fatal", 32'(Fatal), 32'd0);
        chk("rst_state", 32'(Ctrl_state), 32'd0);
        chk("rst_mask", 32'(Fault_mask), 32'd0);
        chk("rst_cnts", 32'({Fault_cnt_A, Fault_cnt_B, Fault_cnt_C}), 32'd0);
        chk("rst_mem_block", 32'(Mem_block), 32'd0);
        tick;
        rst_in = 1'b1;

        // Vector table with scoreboard
        m_cp = 32'd0; m_ca = 4'd0; m_cb = 4'd0; m_cc = 4'd0; m_mask = 3'b000;
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i]);
            #1;
            chk("vec_mem_block", 32'(Mem_block), 32'(vecs[i].mb));
            if (vecs[i].st == 3'd0) m_cp = vecs[i].pca;
            if (vecs[i].st == 3'd1) begin
                m_mask = vecs[i].mask;
                if (m_mask[2]) m_ca = m_ca + 4'd1;
                if (m_mask[1]) m_cb = m_cb + 4'd1;
                if (m_mask[0]) m_cc = m_cc + 4'd1;
            end
            sbq.push_back('{vecs[i].st, m_mask, m_ca, m_cb, m_cc});
            tick;
            e = sbq.pop_front();
            chk("vec_state", 32'(Ctrl_state), 32'(e.st));
            chk("vec_mask", 32'(Fault_mask), 32'(e.mask));
            chk("vec_cnt_a", 32'(Fault_cnt_A), 32'(e.ca));
            chk("vec_cnt_b", 32'(Fault_cnt_B), 32'(e.cb));
            chk("vec_cnt_c", 32'(Fault_cnt_C), 32'(e.cc));
            chk("vec_stall", 32'(Stall), 32'(e.st != 3'd0));
            chk("vec_fatal", 32'(Fatal), 32'(e.st == 3'd4));
            if (vecs[i].st == 3'd1) check_recovery(m_cp);
        end

        // Fatal is sticky even once the cores agree again
        set_all(32'h60, 32'd5);
        for (int k = 0; k < 22; k++) begin
            tick;
            chk("fatal_hold", 32'(Fatal), 32'd1);
            chk("fatal_stall", 32'(Stall), 32'd1);
            chk("fatal_state", 32'(Ctrl_state), 32'd4);
        end
        #2;
        rst_in = 1'b0;
        #1;
        chk("fatal_rst_fatal", 32'(Fatal), 32'd0);
        chk("fatal_rst_stall", 32'(Stall), 32'd0);
        chk("fatal_rst_state", 32'(Ctrl_state), 32'd0);
        chk("fatal_rst_cnts", 32'({Fault_cnt_A, Fault_cnt_B, Fault_cnt_C}), 32'd0);
        tick;
        rst_in = 1'b1;

        // Saturation of C's counter
        for (int it = 0; it < 17; it++) begin
            set_all(32'h40, 32'd5);
            alu_c = 32'd9;
            tick;
            chk("sat_detect", 32'(Ctrl_state), 32'd1);
            set_all(32'h40, 32'd5);
            wait_state(3'd0, 30);
            chk("sat_cnt_c", 32'(Fault_cnt_C), (it < 15) ? it + 1 : 15);
        end
        chk("sat_cnt_a", 32'(Fault_cnt_A), 32'd0);
        chk("sat_cnt_b", 32'(Fault_cnt_B), 32'd0);
        chk("sat_mask", 32'(Fault_mask), 32'b001);

        // Mismatch inside the masked RESUME window
        set_all(32'h50, 32'd5);
        pc_a = 32'h54;
        tick;
        chk("mask_detect", 32'(Ctrl_state), 32'd1);
        chk("mask_cnt_a0", 32'(Fault_cnt_A), 32'd1);
        set_all(32'h50, 32'd5);
        wait_state(3'd3, 20);
        pc_a = 32'h58;
        for (int k = 0; k < R - 1; k++) begin
            tick;
            chk("mask_resume_state", 32'(Ctrl_state), 32'd3);
            chk("mask_resume_stall", 32'(Stall), 32'd0);
            chk("mask_resume_cnt_a", 32'(Fault_cnt_A), 32'd1);
        end
        tick;
        chk("mask_monitor", 32'(Ctrl_state), 32'd0);
        chk("mask_cnt_a1", 32'(Fault_cnt_A), 32'd1);
        chk("mask_mem_block", 32'(Mem_block), 32'd1);
        tick;
        chk("mask_redetect", 32'(Ctrl_state), 32'd1);
        chk("mask_cnt_a2", 32'(Fault_cnt_A), 32'd2);
        chk("mask_cnt_c", 32'(Fault_cnt_C), 32'd15);

        // Asynchronous reset mid-STALL
        tick;
        chk("async_pre_stall", 32'(Stall), 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_stall", 32'(Stall), 32'd0);
        chk("async_state", 32'(Ctrl_state), 32'd0);
        chk("async_mask", 32'(Fault_mask), 32'd0);
        chk("async_cnts", 32'({Fault_cnt_A, Fault_cnt_B, Fault_cnt_C}), 32'd0);
        tick;
        rst_in = 1'b1;
        set_all(32'h70, 32'd5);
        tick;
        chk("post_rst_state", 32'(Ctrl_state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
